irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the peripheral interrupt lines (timer_int[1:0], UART RX ready, keyboard pressed, …) and the CPU interrupt input.
- Captures and masks the requests, then prioritises them and presents one vectored request at a time to the CPU.
- Tracks a single in-service interrupt and clears it on end-of-interrupt.
- Sits on the MMIO bus beside the peripheral register block and decodes its own 8-bit offset window.

Parameters:
- N_SRC, 8, number of interrupt sources (1..16); index 0 is highest priority.
- ID_W, 3, width of the vector/id field; must satisfy 2^ID_W >= N_SRC.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- irq_src  in  N_SRC  raw interrupt lines from peripherals, synchronous to clk
- sel  in  1  bus select for this block's window
- we  in  1  write strobe, valid with sel
- addr  in  8  byte offset within window
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr; 0 when sel=0 or offset unmapped
- int_req  out  1  interrupt request to CPU
- int_vec  out  ID_W  id of the requested source; valid while int_req=1
- int_ack  in  1  one-cycle pulse: CPU accepts the request
- eoi  in  1  one-cycle pulse: CPU finished the handler (eret)

Behaviour:
Registers (word offsets; bits above N_SRC read 0, writes to them are ignored):
- 0x00 PEND: read gives pending bits. Writing 1 clears an edge-mode bit (W1C). Level-mode bits ignore writes.
- 0x04 MASK: R/W; 1 = enabled.
- 0x08 MODE: R/W; 1 = edge, 0 = level.
- 0x0C CTRL: bit0 = global enable (GEN), R/W.
- 0x10 STAT: read-only = {ID_W-bit cur_id at bits [ID_W+7:8], bit1 = in_service, bit0 = int_req}.

Pending capture:
- irq_d <= irq_src every cycle.
- Edge mode: pend[i] sets when irq_src[i] & ~irq_d[i]. If a set and a W1C/ack-clear hit the same bit in the same cycle, the set wins.
- Level mode: pend[i] <= irq_src[i] every cycle; ack does not clear it.
- A rising edge at cycle t is visible in PEND at t+1.

Selection:
- eligible = pend & MASK, qualified by GEN.
- The winner is the lowest set index, computed combinationally.

FSM (state register; int_req and int_vec are registered):
- IDLE:
  - If eligible != 0, go to REQ next cycle and latch int_vec = winner.
  - int_req=1 is therefore asserted 1 cycle after the pending bit is visible, i.e. 2 cycles after an input edge.
- REQ:
  - int_req=1; int_vec holds its latched value. A later higher-priority arrival does not change it.
  - int_ack: clear pend[int_vec] if that source is edge mode, set in_service, cur_id <= int_vec, int_req <= 0, go to SERVICE.
  - Withdraw: if pend[int_vec] & MASK[int_vec] & GEN becomes 0 before the ack, drop int_req next cycle and return to IDLE. Re-arbitration may then occur the cycle after.
  - If ack and withdraw condition occur in the same cycle, the ack wins.
- SERVICE:
  - int_req=0; no nesting, so new requests stay pending only.
  - eoi: clear in_service, go to IDLE. Re-arbitration happens the cycle after returning to IDLE.
  - int_ack in SERVICE or IDLE is ignored.
  - eoi in IDLE or REQ is ignored.

Reset (synchronous, active-high):
- Clears pend, MASK, MODE, GEN, irq_d, cur_id and in_service; state = IDLE; int_req=0, int_vec=0.
- rdata is combinational, so it reads all-zero registers after reset.
- Reset in REQ or SERVICE aborts immediately; the CPU must tolerate int_req dropping.

Register write timing:
- Writes take effect at the clock edge; the new value is readable the next cycle.
- A MASK/MODE/GEN write and the FSM observe the updated value the following cycle.

Test Plan:
- Reset, then read all offsets -> all 0; int_req=0.
- MODE=0xFF, MASK=0x0C, GEN=1; pulse irq_src[3] at t0 -> PEND=0x08 at t0+1, int_req=1 with int_vec=3 at t0+2; ack -> PEND=0, STAT.in_service=1, cur_id=3; eoi -> IDLE, int_req stays 0.
- Edges on sources 5 and 2 in the same cycle, MASK=0xFF -> vec=2 first. After ack+eoi -> vec=5 issued 2 cycles after eoi.
- Source 6 in REQ, then write MASK bit6=0 before ack -> int_req drops the next cycle, PEND bit6 still 1. Re-enable the mask -> request is re-issued with vec=6.
- Level-mode source 1 held high: ack -> PEND bit1 stays 1; W1C to PEND bit1 has no effect; after eoi, int_req re-asserts with vec=1. Drop the line -> PEND clears the next cycle.
- Edge on source 4 in the same cycle as a W1C of bit4 -> PEND bit4 = 1. Assert rst while in SERVICE -> next cycle all state is 0 and int_req=0.

Source files
------------

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: captures and masks peripheral requests, then
// issues one prioritised request at a time to the CPU and tracks the handler in service.
module irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             sel,
  input  logic             we,
  input  logic [7:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             int_req,
  output logic [ID_W-1:0]  int_vec,
  input  logic             int_ack,
  input  logic             eoi
);

  localparam int NV = 1 << ID_W;

  localparam logic [7:0] OFS_PEND = 8'h00;
  localparam logic [7:0] OFS_MASK = 8'h04;
  localparam logic [7:0] OFS_MODE = 8'h08;
  localparam logic [7:0] OFS_CTRL = 8'h0C;
  localparam logic [7:0] OFS_STAT = 8'h10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t state, state_next;

  logic [N_SRC-1:0] pend, mask, mode, irq_d;
  logic             gen;
  logic [ID_W-1:0]  cur_id, cur_id_next, int_vec_next;
  logic             in_service, in_service_next, int_req_next;

  logic [N_SRC-1:0] eligible, rise, w1c, ack_clr, pend_next;
  logic [NV-1:0]    elig_ext;
  logic [ID_W-1:0]  winner;
  logic             any_elig;
  logic             ack_take;
  logic             wr_pend, wr_mask, wr_mode, wr_ctrl;
  logic             unused_wdata;

  assign wr_pend = sel & we & (addr == OFS_PEND);
  assign wr_mask = sel & we & (addr == OFS_MASK);
  assign wr_mode = sel & we & (addr == OFS_MODE);
  assign wr_ctrl = sel & we & (addr == OFS_CTRL);

  assign unused_wdata = ^wdata[31:N_SRC];

  assign eligible = pend & mask & {N_SRC{gen}};
  assign elig_ext = NV'(eligible);
  assign any_elig = |eligible;
  assign rise     = irq_src & ~irq_d;
  assign w1c      = wr_pend ? wdata[N_SRC-1:0] : '0;

  // Scan from the bottom of the priority order so the lowest set index wins.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack_take & (int_vec == ID_W'(i));
    end
  end

  // Level bits follow the line; in edge bits a fresh rising edge beats any clear.
  assign pend_next = (mode & (rise | (pend & ~(w1c | ack_clr)))) | (~mode & irq_src);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_d <= '0;
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      gen   <= 1'b0;
    end else begin
      irq_d <= irq_src;
      pend  <= pend_next;
      if (wr_mask) mask <= wdata[N_SRC-1:0];
      if (wr_mode) mode <= wdata[N_SRC-1:0];
      if (wr_ctrl) gen  <= wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_vec    <= '0;
      cur_id     <= '0;
      in_service <= 1'b0;
    end else begin
      state      <= state_next;
      int_req    <= int_req_next;
      int_vec    <= int_vec_next;
      cur_id     <= cur_id_next;
      in_service <= in_service_next;
    end
  end

  // An ack in REQ takes precedence over a simultaneous withdrawal.
  always_comb begin
    state_next      = state;
    int_req_next    = int_req;
    int_vec_next    = int_vec;
    cur_id_next     = cur_id;
    in_service_next = in_service;
    ack_take        = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          state_next   = REQ;
          int_req_next = 1'b1;
          int_vec_next = winner;
        end
      end
      REQ: begin
        if (int_ack) begin
          ack_take        = 1'b1;
          state_next      = SERVICE;
          in_service_next = 1'b1;
          cur_id_next     = int_vec;
          int_req_next    = 1'b0;
        end else if (!elig_ext[int_vec]) begin
          state_next   = IDLE;
          int_req_next = 1'b0;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_next      = IDLE;
          in_service_next = 1'b0;
        end
      end
      default: begin
        state_next   = IDLE;
        int_req_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        OFS_PEND: rdata[N_SRC-1:0] = pend;
        OFS_MASK: rdata[N_SRC-1:0] = mask;
        OFS_MODE: rdata[N_SRC-1:0] = mode;
        OFS_CTRL: rdata[0]         = gen;
        OFS_STAT: begin
          rdata[ID_W+7:8] = cur_id;
          rdata[1]        = in_service;
          rdata[0]        = int_req;
        end
        default: rdata = '0;
      endcase
    end
  end

endmodule
